// File: rtl/mem_chk_pkg.sv
// Shared types and error-bit positions for the checked memory.
package mem_chk_pkg;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    READY = 2'd1,
    OFF   = 2'd2
  } state_e;

  localparam int unsigned ERR_W     = 5;
  localparam int unsigned ERR_RDWR  = 0;
  localparam int unsigned ERR_ADDR  = 1;
  localparam int unsigned ERR_CEN   = 2;
  localparam int unsigned ERR_STATE = 3;
  localparam int unsigned ERR_PAR   = 4;

endpackage

// File: rtl/mem_chk_array.sv
// Single-port RAM: synchronous write, combinational read on the same address.
module mem_chk_array
  import mem_chk_pkg::*;
#(
  parameter int unsigned AW    = 12,
  parameter int unsigned WW    = 9,
  parameter int unsigned DEPTH = 4096
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [WW-1:0] wdata_i,
  output logic [WW-1:0] rdata_c
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WW-1:0] mem_q [DEPTH];
  logic [IW-1:0] idx_c;

  assign idx_c   = addr_i[IW-1:0];
  assign rdata_c = mem_q[idx_c];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[idx_c] <= wdata_i;
  end

endmodule

// File: rtl/mem_chk_top.sv
// Checked memory: init sweep FSM, access screening, sticky error flags and counter.
module mem_chk_top
  import mem_chk_pkg::*;
#(
  parameter int unsigned DW        = 8,
  parameter int unsigned AW        = 12,
  parameter int unsigned DEPTH     = 4096,
  parameter int unsigned PARITY_EN = 1,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cen,
  input  logic             rd,
  input  logic             wr,
  input  logic [AW-1:0]    add,
  input  logic [DW-1:0]    din,
  input  logic             pwr_ok,
  input  logic             err_clr,
  output logic [DW-1:0]    dout,
  output logic             rvalid,
  output logic             busy,
  output logic [ERR_W-1:0] err_flags,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int unsigned WW = DW + PARITY_EN;

  state_e           state_q, state_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic [DW-1:0]    dout_q, dout_d;
  logic             rvalid_q, rvalid_d;
  logic             busy_q, busy_d;
  logic [ERR_W-1:0] flags_q, flags_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             we_c, acc_c, legal_c, rd_ok_c, par_bad_c;
  logic [AW-1:0]    addr_c;
  logic [DW-1:0]    wbits_c;
  logic [WW-1:0]    wword_c, rword_c;
  logic [ERR_W-1:0] new_err_c;

  // Even parity: stored bit makes the XOR over the whole word zero.
  if (PARITY_EN != 0) begin : g_par
    assign wword_c   = {^wbits_c, wbits_c};
    assign par_bad_c = ^rword_c;
  end else begin : g_nopar
    assign wword_c   = wbits_c;
    assign par_bad_c = 1'b0;
  end

  mem_chk_array #(.AW(AW), .WW(WW), .DEPTH(DEPTH)) u_array (
    .clk     (clk),
    .we_i    (we_c),
    .addr_i  (addr_c),
    .wdata_i (wword_c),
    .rdata_c (rword_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= INIT;
      ptr_q    <= '0;
      dout_q   <= '0;
      rvalid_q <= 1'b0;
      busy_q   <= 1'b1;
      flags_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      dout_q   <= dout_d;
      rvalid_q <= rvalid_d;
      busy_q   <= busy_d;
      flags_q  <= flags_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    we_c      = 1'b0;
    addr_c    = add;
    wbits_c   = din;
    new_err_c = '0;
    dout_d    = dout_q;
    flags_d   = flags_q;
    cnt_d     = cnt_q;

    // Screening: every applicable fault bit is raised together.
    acc_c = rd | wr;
    if (acc_c) begin
      new_err_c[ERR_RDWR]  = rd & wr;
      new_err_c[ERR_ADDR]  = 32'(add) >= DEPTH;
      new_err_c[ERR_CEN]   = cen;
      new_err_c[ERR_STATE] = (state_q != READY) || !pwr_ok;
    end
    legal_c = acc_c && (new_err_c == '0);
    rd_ok_c = legal_c & rd;
    if (rd_ok_c) new_err_c[ERR_PAR] = par_bad_c;

    case (state_q)
      INIT: begin
        if (!pwr_ok) begin
          state_d = OFF;
        end else begin
          we_c    = 1'b1;
          addr_c  = ptr_q;
          wbits_c = '0;
          if (ptr_q == AW'(DEPTH - 1)) begin
            state_d = READY;
            ptr_d   = '0;
          end else begin
            ptr_d = ptr_q + AW'(1);
          end
        end
      end
      READY: begin
        if (!pwr_ok)            state_d = OFF;
        else if (legal_c && wr) we_c    = 1'b1;
      end
      OFF: begin
        if (pwr_ok) begin
          state_d = INIT;
          ptr_d   = '0;
        end
      end
      default: state_d = INIT;
    endcase

    if (cen)          dout_d = '0;
    else if (rd_ok_c) dout_d = rword_c[DW-1:0];
    rvalid_d = rd_ok_c;
    busy_d   = (state_d != READY);

    // A clear coinciding with a new fault keeps only the new fault.
    if (err_clr) begin
      flags_d = new_err_c;
      cnt_d   = (|new_err_c) ? CNT_W'(1) : '0;
    end else if (|new_err_c) begin
      flags_d = flags_q | new_err_c;
      cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    end
  end

  assign dout      = dout_q;
  assign rvalid    = rvalid_q;
  assign busy      = busy_q;
  assign err_flags = flags_q;
  assign err_cnt   = cnt_q;

endmodule
